// File: rtl/note_voice_alloc_if.sv
// Keyboard message strobe in, per-voice tone-generator controls out.
// The scanner/bench side uses master, the allocator uses slave.
interface note_voice_alloc_if #(
    parameter int VOICES = 4
);
    logic                  clk_msg;
    logic [7:0]            msg;
    logic [VOICES*7-1:0]   voice_note;
    logic [VOICES-1:0]     voice_on;
    logic [VOICES-1:0]     voice_trig;
    logic                  voice_steal;
    logic                  msg_drop;

    modport master (
        output clk_msg,
        output msg,
        input  voice_note,
        input  voice_on,
        input  voice_trig,
        input  voice_steal,
        input  msg_drop
    );

    modport slave (
        input  clk_msg,
        input  msg,
        output voice_note,
        output voice_on,
        output voice_trig,
        output voice_steal,
        output msg_drop
    );
endinterface

// File: rtl/note_voice_alloc.sv
// Polyphonic voice allocator: synchronises the slow key-scanner strobe, decodes
// note-on/off and assigns notes to voices with retrigger, free-slot and oldest-steal policy.
module note_voice_alloc #(
    parameter int VOICES = 4,
    parameter int AGE_W  = 3
) (
    input  logic              clk,
    input  logic              rst,
    note_voice_alloc_if.slave bus
);
    localparam int                 IDX_W   = $clog2(VOICES);
    localparam logic [AGE_W-1:0]   AGE_MAX = AGE_W'(VOICES - 1);

    typedef enum logic [1:0] {
        IDLE,
        LOOKUP,
        APPLY
    } state_t;

    state_t              state_q, state_d;

    logic                s1_q, s2_q, s3_q;
    logic                rise;

    logic [7:0]          msg_q, msg_d;
    logic [VOICES-1:0]   hit_q, hit_d;
    logic [IDX_W-1:0]    free_idx_q, free_idx_d;
    logic                free_ok_q, free_ok_d;
    logic [IDX_W-1:0]    old_idx_q, old_idx_d;

    logic [6:0]          note_q [VOICES];
    logic [6:0]          note_d [VOICES];
    logic [AGE_W-1:0]    age_q  [VOICES];
    logic [AGE_W-1:0]    age_d  [VOICES];
    logic [VOICES-1:0]   on_q, on_d;
    logic [VOICES-1:0]   trig_q, trig_d;
    logic                steal_q, steal_d;
    logic                drop_q, drop_d;

    logic [VOICES-1:0]   hit_c;
    logic [IDX_W-1:0]    free_idx_c;
    logic                free_ok_c;
    logic [IDX_W-1:0]    old_idx_c;
    logic [AGE_W-1:0]    best_age;
    logic                old_found;
    logic [IDX_W-1:0]    hit_lo;
    logic [IDX_W-1:0]    target;
    logic                write_note;
    logic                set_on;
    logic [VOICES*7-1:0] note_flat;

    function automatic logic [AGE_W-1:0] age_inc(input logic [AGE_W-1:0] a);
        return (a >= AGE_MAX) ? a : a + AGE_W'(1);
    endfunction

    // Edge detect one stage past the two-flop synchroniser
    assign rise = s2_q & ~s3_q;

    always_comb begin
        hit_c      = '0;
        free_idx_c = '0;
        free_ok_c  = 1'b0;
        old_idx_c  = '0;
        best_age   = '0;
        old_found  = 1'b0;
        for (int i = 0; i < VOICES; i++) begin
            if (on_q[i] && (note_q[i] == msg_q[6:0])) begin
                hit_c[i] = 1'b1;
            end
            if (on_q[i] && (!old_found || (age_q[i] > best_age))) begin
                old_found = 1'b1;
                best_age  = age_q[i];
                old_idx_c = IDX_W'(i);
            end
        end
        for (int i = VOICES - 1; i >= 0; i--) begin
            if (!on_q[i]) begin
                free_ok_c  = 1'b1;
                free_idx_c = IDX_W'(i);
            end
        end
    end

    always_comb begin
        hit_lo = '0;
        for (int i = VOICES - 1; i >= 0; i--) begin
            if (hit_q[i]) begin
                hit_lo = IDX_W'(i);
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        msg_d      = msg_q;
        hit_d      = hit_q;
        free_idx_d = free_idx_q;
        free_ok_d  = free_ok_q;
        old_idx_d  = old_idx_q;
        note_d     = note_q;
        age_d      = age_q;
        on_d       = on_q;
        trig_d     = '0;
        steal_d    = 1'b0;
        drop_d     = 1'b0;
        target     = '0;
        write_note = 1'b0;
        set_on     = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (rise) begin
                    msg_d   = bus.msg;
                    state_d = LOOKUP;
                end
            end
            LOOKUP: begin
                drop_d     = rise;
                hit_d      = hit_c;
                free_idx_d = free_idx_c;
                free_ok_d  = free_ok_c;
                old_idx_d  = old_idx_c;
                state_d    = APPLY;
            end
            APPLY: begin
                drop_d  = rise;
                state_d = IDLE;
                if (msg_q[7]) begin
                    if (|hit_q) begin
                        target = hit_lo;
                    end else if (free_ok_q) begin
                        target     = free_idx_q;
                        write_note = 1'b1;
                        set_on     = 1'b1;
                    end else begin
                        target     = old_idx_q;
                        write_note = 1'b1;
                        steal_d    = 1'b1;
                    end
                    // Ageing uses the pre-update gate so a freshly claimed voice starts at 0
                    for (int i = 0; i < VOICES; i++) begin
                        if (IDX_W'(i) == target) begin
                            trig_d[i] = 1'b1;
                            age_d[i]  = '0;
                            if (write_note) begin
                                note_d[i] = msg_q[6:0];
                            end
                            if (set_on) begin
                                on_d[i] = 1'b1;
                            end
                        end else if (on_q[i]) begin
                            age_d[i] = age_inc(age_q[i]);
                        end
                    end
                end else begin
                    for (int i = 0; i < VOICES; i++) begin
                        if (hit_q[i]) begin
                            on_d[i]  = 1'b0;
                            age_d[i] = '0;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Sync chain presets high so a strobe already high at reset release is ignored
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q       <= 1'b1;
            s2_q       <= 1'b1;
            s3_q       <= 1'b1;
            state_q    <= IDLE;
            msg_q      <= '0;
            hit_q      <= '0;
            free_idx_q <= '0;
            free_ok_q  <= 1'b0;
            old_idx_q  <= '0;
            on_q       <= '0;
            trig_q     <= '0;
            steal_q    <= 1'b0;
            drop_q     <= 1'b0;
            for (int i = 0; i < VOICES; i++) begin
                note_q[i] <= '0;
                age_q[i]  <= '0;
            end
        end else begin
            s1_q       <= bus.clk_msg;
            s2_q       <= s1_q;
            s3_q       <= s2_q;
            state_q    <= state_d;
            msg_q      <= msg_d;
            hit_q      <= hit_d;
            free_idx_q <= free_idx_d;
            free_ok_q  <= free_ok_d;
            old_idx_q  <= old_idx_d;
            on_q       <= on_d;
            trig_q     <= trig_d;
            steal_q    <= steal_d;
            drop_q     <= drop_d;
            for (int i = 0; i < VOICES; i++) begin
                note_q[i] <= note_d[i];
                age_q[i]  <= age_d[i];
            end
        end
    end

    always_comb begin
        note_flat = '0;
        for (int i = 0; i < VOICES; i++) begin
            note_flat[7*i +: 7] = note_q[i];
        end
    end

    assign bus.voice_note  = note_flat;
    assign bus.voice_on    = on_q;
    assign bus.voice_trig  = trig_q;
    assign bus.voice_steal = steal_q;
    assign bus.msg_drop    = drop_q;
endmodule

// File: tb/tb_note_voice_alloc.sv
// Bench for note_voice_alloc: vector table plus hand sequences, with a
// cycle-stamped scoreboard checked on the falling clock edge.
module tb_note_voice_alloc;
    localparam int VOICES = 4;
    localparam int AGE_W  = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    note_voice_alloc_if #(.VOICES(VOICES)) bus ();

    note_voice_alloc #(.VOICES(VOICES), .AGE_W(AGE_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        int          due;
        logic [3:0]  on;
        logic [27:0] note;
        logic [3:0]  trig;
        logic        steal;
        logic        drop;
        string       name;
    } exp_t;

    typedef struct {
        logic        rst_before;
        logic [7:0]  msg;
        logic [3:0]  on;
        logic [27:0] note;
        logic [3:0]  trig;
        logic        steal;
    } vec_t;

    exp_t sb [$];
    vec_t vt [$];

    int cyc         = 0;
    int vectors     = 0;
    int miscompares = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [27:0] pk(input int a, input int b, input int c, input int d);
        return {7'(d), 7'(c), 7'(b), 7'(a)};
    endfunction

    task automatic push(input int due, input logic [3:0] on, input logic [27:0] note,
                        input logic [3:0] trig, input logic steal, input logic drop,
                        input string nm);
        exp_t e;
        e.due   = due;
        e.on    = on;
        e.note  = note;
        e.trig  = trig;
        e.steal = steal;
        e.drop  = drop;
        e.name  = nm;
        sb.push_back(e);
    endtask

    task automatic add_vec(input logic r, input logic [7:0] m, input logic [3:0] on,
                           input logic [27:0] note, input logic [3:0] trig, input logic steal);
        vec_t v;
        v.rst_before = r;
        v.msg        = m;
        v.on         = on;
        v.note       = note;
        v.trig       = trig;
        v.steal      = steal;
        vt.push_back(v);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0 && sb[0].due == cyc) begin
            e = sb.pop_front();
            vectors++;
            if (bus.voice_on !== e.on || bus.voice_note !== e.note || bus.voice_trig !== e.trig ||
                bus.voice_steal !== e.steal || bus.msg_drop !== e.drop) begin
                miscompares++;
                $display("FAIL %s cyc=%0d got on=%b note=%h trig=%b steal=%b drop=%b want on=%b note=%h trig=%b steal=%b drop=%b",
                         e.name, cyc, bus.voice_on, bus.voice_note, bus.voice_trig, bus.voice_steal,
                         bus.msg_drop, e.on, e.note, e.trig, e.steal, e.drop);
            end
        end else if (!rst && (bus.voice_trig !== 4'b0000 || bus.voice_steal !== 1'b0 ||
                              bus.msg_drop !== 1'b0)) begin
            miscompares++;
            $display("FAIL spurious_pulse cyc=%0d got trig=%b steal=%b drop=%b want all 0",
                     cyc, bus.voice_trig, bus.voice_steal, bus.msg_drop);
        end
    end

    task automatic do_reset(input logic hold_high);
        @(posedge clk); #1;
        rst         = 1'b1;
        bus.clk_msg = hold_high;
        bus.msg     = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        push(cyc, 4'b0000, 28'h0, 4'b0000, 1'b0, 1'b0, "reset");
    endtask

    // Outputs land 5 edges after the strobe is raised just past an edge
    task automatic send(input logic [7:0] m, input logic [3:0] on, input logic [27:0] note,
                        input logic [3:0] trig, input logic steal, input string nm);
        int k;
        @(posedge clk); #1;
        bus.msg     = m;
        bus.clk_msg = 1'b1;
        k           = cyc;
        push(k + 5, on, note, trig, steal, 1'b0, nm);
        repeat (3) @(posedge clk);
        #1;
        bus.clk_msg = 1'b0;
        @(posedge clk); #1;
        bus.msg = 8'h5A;
        repeat (5) @(posedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d pending=%0d want completion", cyc, sb.size());
        $fatal(1, "timeout");
    end

    initial begin
        int k;
        bus.clk_msg = 1'b0;
        bus.msg     = 8'h00;

        // two voices fill in order
        add_vec(1, 8'hBC, 4'b0001, pk(60, 0, 0, 0), 4'b0001, 0);
        add_vec(0, 8'hC0, 4'b0011, pk(60, 64, 0, 0), 4'b0010, 0);
        // fill all four, then steal the oldest twice
        add_vec(1, 8'hBC, 4'b0001, pk(60, 0, 0, 0), 4'b0001, 0);
        add_vec(0, 8'hBE, 4'b0011, pk(60, 62, 0, 0), 4'b0010, 0);
        add_vec(0, 8'hC0, 4'b0111, pk(60, 62, 64, 0), 4'b0100, 0);
        add_vec(0, 8'hC1, 4'b1111, pk(60, 62, 64, 65), 4'b1000, 0);
        add_vec(0, 8'hC3, 4'b1111, pk(67, 62, 64, 65), 4'b0001, 1);
        add_vec(0, 8'hC5, 4'b1111, pk(67, 69, 64, 65), 4'b0010, 1);
        // note-off keeps the note, freed slot reused
        add_vec(1, 8'hBC, 4'b0001, pk(60, 0, 0, 0), 4'b0001, 0);
        add_vec(0, 8'hBE, 4'b0011, pk(60, 62, 0, 0), 4'b0010, 0);
        add_vec(0, 8'h3C, 4'b0010, pk(60, 62, 0, 0), 4'b0000, 0);
        add_vec(0, 8'hC0, 4'b0011, pk(64, 62, 0, 0), 4'b0001, 0);
        // retrigger, then note-off of an unheld note
        add_vec(1, 8'hBC, 4'b0001, pk(60, 0, 0, 0), 4'b0001, 0);
        add_vec(0, 8'hBC, 4'b0001, pk(60, 0, 0, 0), 4'b0001, 0);
        add_vec(0, 8'h45, 4'b0001, pk(60, 0, 0, 0), 4'b0000, 0);
        // saturated age tie between v0 and v1 resolves to v0
        add_vec(1, 8'hBC, 4'b0001, pk(60, 0, 0, 0), 4'b0001, 0);
        add_vec(0, 8'hBE, 4'b0011, pk(60, 62, 0, 0), 4'b0010, 0);
        add_vec(0, 8'h3C, 4'b0010, pk(60, 62, 0, 0), 4'b0000, 0);
        add_vec(0, 8'hC0, 4'b0011, pk(64, 62, 0, 0), 4'b0001, 0);
        add_vec(0, 8'hC1, 4'b0111, pk(64, 62, 65, 0), 4'b0100, 0);
        add_vec(0, 8'hC3, 4'b1111, pk(64, 62, 65, 67), 4'b1000, 0);
        add_vec(0, 8'hC3, 4'b1111, pk(64, 62, 65, 67), 4'b1000, 0);
        add_vec(0, 8'hC5, 4'b1111, pk(69, 62, 65, 67), 4'b0001, 1);

        // reset with strobe held high: nothing may happen afterwards
        do_reset(1'b1);
        for (int j = 1; j <= 20; j++) begin
            push(cyc + j, 4'b0000, 28'h0, 4'b0000, 1'b0, 1'b0, "idle_after_rst");
        end
        repeat (20) @(posedge clk);
        #1;
        bus.clk_msg = 1'b0;
        repeat (4) @(posedge clk);

        for (int i = 0; i < vt.size(); i++) begin
            if (vt[i].rst_before) begin
                do_reset(1'b0);
            end
            send(vt[i].msg, vt[i].on, vt[i].note, vt[i].trig, vt[i].steal,
                 $sformatf("vec%0d", i));
        end

        // second edge arrives while the first event is in APPLY
        do_reset(1'b0);
        @(posedge clk); #1;
        bus.msg     = 8'hBC;
        bus.clk_msg = 1'b1;
        k           = cyc;
        push(k + 5, 4'b0001, pk(60, 0, 0, 0), 4'b0001, 1'b0, 1'b1, "drop");
        @(posedge clk); #1;
        bus.clk_msg = 1'b0;
        @(posedge clk); #1;
        bus.clk_msg = 1'b1;
        @(posedge clk); #1;
        bus.clk_msg = 1'b0;
        repeat (8) @(posedge clk);

        // reset lands while the event is in LOOKUP
        @(posedge clk); #1;
        bus.msg     = 8'hC0;
        bus.clk_msg = 1'b1;
        k           = cyc;
        repeat (3) @(posedge clk);
        #1;
        rst         = 1'b1;
        bus.clk_msg = 1'b0;
        push(k + 4, 4'b0000, 28'h0, 4'b0000, 1'b0, 1'b0, "rst_in_lookup");
        @(posedge clk); #1;
        rst = 1'b0;
        push(cyc + 1, 4'b0000, 28'h0, 4'b0000, 1'b0, 1'b0, "rst_in_lookup_after");
        repeat (6) @(posedge clk);
        send(8'hC0, 4'b0001, pk(64, 0, 0, 0), 4'b0001, 1'b0, "post_rst");

        repeat (10) @(posedge clk);
        #1;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain got pending=%0d want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
